// File: rtl/frame_status_tx.sv
// Serialises a snapshot of the pulse settings as a command-format frame onto the uart_tx byte port.
// Define FRAME_CKSUM_EN to append a modulo-256 checksum byte (10-byte frame instead of 9).
module frame_status_tx #(
    parameter int         UART_BPS    = 9600,
    parameter int         CLK_FREQ    = 50_000_000,
    parameter logic [7:0] HEADER      = 8'h07,
    parameter int         BYTE_CYCLES = (CLK_FREQ / UART_BPS) * 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        send_req,
    input  logic        en1,
    input  logic        en2,
    input  logic [15:0] pulse_width1,
    input  logic [15:0] pulse_width2,
    input  logic [15:0] pulse_gap,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        busy,
    output logic        done
);

    localparam int             CNT_W    = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_CYCLES - 1);
`ifdef FRAME_CKSUM_EN
    localparam logic [3:0]     LAST_IDX = 4'd9;
`else
    localparam logic [3:0]     LAST_IDX = 4'd8;
`endif

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_flag_q, tx_flag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             en1_q, en1_d;
    logic             en2_q, en2_d;
    logic [15:0]      w1_q, w1_d;
    logic [15:0]      w2_q, w2_d;
    logic [15:0]      gap_q, gap_d;
    logic [7:0]       cur_byte;

`ifdef FRAME_CKSUM_EN
    logic [7:0] cksum;

    assign cksum = HEADER + {7'b0, en1_q} + {7'b0, en2_q}
                 + w1_q[15:8] + w1_q[7:0]
                 + w2_q[15:8] + w2_q[7:0]
                 + gap_q[15:8] + gap_q[7:0];
`endif

    // Byte selected from the latched snapshot, never from the live inputs.
    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            4'd0: cur_byte = HEADER;
            4'd1: cur_byte = {7'b0, en1_q};
            4'd2: cur_byte = {7'b0, en2_q};
            4'd3: cur_byte = w1_q[15:8];
            4'd4: cur_byte = w1_q[7:0];
            4'd5: cur_byte = w2_q[15:8];
            4'd6: cur_byte = w2_q[7:0];
            4'd7: cur_byte = gap_q[15:8];
            4'd8: cur_byte = gap_q[7:0];
`ifdef FRAME_CKSUM_EN
            4'd9: cur_byte = cksum;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_flag_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        en1_d     = en1_q;
        en2_d     = en2_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                if (send_req) begin
                    en1_d   = en1;
                    en2_d   = en2;
                    w1_d    = pulse_width1;
                    w2_d    = pulse_width2;
                    gap_d   = pulse_gap;
                    busy_d  = 1'b1;
                    idx_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_data_d = cur_byte;
                tx_flag_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // Slot lasts BYTE_CYCLES cycles here plus the SEND cycle.
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SEND;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            tx_flag_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en1_q     <= 1'b0;
            en2_q     <= 1'b0;
            w1_q      <= 16'h0000;
            w2_q      <= 16'h0000;
            gap_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_flag_q <= tx_flag_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en1_q     <= en1_d;
            en2_q     <= en2_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            gap_q     <= gap_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_flag = tx_flag_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_frame_status_tx.sv
// Directed bench for frame_status_tx: frame contents, slot timing, snapshot, reset and back-to-back frames.
module tb_frame_status_tx;

    localparam int BC   = 20;
    localparam int SLOT = BC + 1;
`ifdef FRAME_CKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic        sys_clk;
    logic        sys_rst_n;
    logic        send_req;
    logic        en1;
    logic        en2;
    logic [15:0] pulse_width1;
    logic [15:0] pulse_width2;
    logic [15:0] pulse_gap;
    logic [7:0]  tx_data;
    logic        tx_flag;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;
    int cyc;
    int done_cnt;
    int busy_cnt;
    logic [7:0] flag_data[$];
    int         flag_cyc[$];

    logic [7:0] exp_basic [10];

    frame_status_tx #(.BYTE_CYCLES(BC)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .send_req     (send_req),
        .en1          (en1),
        .en2          (en2),
        .pulse_width1 (pulse_width1),
        .pulse_width2 (pulse_width2),
        .pulse_gap    (pulse_gap),
        .tx_data      (tx_data),
        .tx_flag      (tx_flag),
        .busy         (busy),
        .done         (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observation log only; expectations are computed separately.
    initial begin
        done_cnt = 0;
        busy_cnt = 0;
    end
    always @(negedge sys_clk) begin
        if (tx_flag === 1'b1) begin
            flag_data.push_back(tx_data);
            flag_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    function automatic logic [7:0] model_byte(input int i, input logic e1, input logic e2,
                                              input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] g);
        logic [7:0] f [10];
        f[0] = 8'h07;
        f[1] = {7'b0, e1};
        f[2] = {7'b0, e2};
        f[3] = a[15:8];
        f[4] = a[7:0];
        f[5] = b[15:8];
        f[6] = b[7:0];
        f[7] = g[15:8];
        f[8] = g[7:0];
        f[9] = 8'h00;
        for (int j = 0; j < 9; j++) f[9] = f[9] + f[j];
        return f[i];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic set_basic();
        en1          = 1'b1;
        en2          = 1'b1;
        pulse_width1 = 16'h0008;
        pulse_width2 = 16'h0005;
        pulse_gap    = 16'h0012;
    endtask

    task automatic pulse_req(output int edge_cyc);
        @(negedge sys_clk);
        send_req = 1'b1;
        edge_cyc = cyc + 1;
        @(negedge sys_clk);
        send_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_flags(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            #1;
            if (flag_data.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %0h want 00", tx_data); end
        vectors++;
        if (tx_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_flag: got %0b want 0", tx_flag); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
        sys_rst_n = 1'b1;
        idle(3);
        vectors++;
        if (flag_data.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: flags %0d busy %0b want 0 0", flag_data.size(), busy);
        end
    endtask

    task automatic test_basic_frame();
        int k, bf, bd, bb;
        bit ok;
        set_basic();
        bf = flag_data.size();
        bd = done_cnt;
        bb = busy_cnt;
        pulse_req(k);
        wait_done(NB * SLOT + 20, ok);
        idle(2);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL basic_timeout: no done within budget"); end
        vectors++;
        if (flag_data.size() - bf != NB) begin
            miscompares++;
            $display("[TB] FAIL basic_flag_count: got %0d want %0d", flag_data.size() - bf, NB);
        end
        for (int i = 0; i < NB; i++) begin
            if (bf + i < flag_data.size()) begin
                vectors++;
                if (flag_data[bf + i] !== exp_basic[i]) begin
                    miscompares++;
                    $display("[TB] FAIL basic_byte%0d: got %0h want %0h", i, flag_data[bf + i], exp_basic[i]);
                end
            end
        end
        if (flag_data.size() - bf == NB) begin
            // Request sampled at edge k: flag is visible after edge k+1.
            vectors++;
            if (flag_cyc[bf] - k != 1) begin
                miscompares++;
                $display("[TB] FAIL basic_latency: got %0d want 1", flag_cyc[bf] - k);
            end
            for (int i = 1; i < NB; i++) begin
                vectors++;
                if (flag_cyc[bf + i] - flag_cyc[bf + i - 1] != SLOT) begin
                    miscompares++;
                    $display("[TB] FAIL basic_spacing%0d: got %0d want %0d", i,
                             flag_cyc[bf + i] - flag_cyc[bf + i - 1], SLOT);
                end
            end
        end
        vectors++;
        if (busy_cnt - bb != NB * SLOT + 1) begin
            miscompares++;
            $display("[TB] FAIL basic_busy_len: got %0d want %0d", busy_cnt - bb, NB * SLOT + 1);
        end
        vectors++;
        if (done_cnt - bd != 1) begin miscompares++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt - bd); end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_end_state: busy %0b done %0b want 0 0", busy, done);
        end
        vectors++;
        if (tx_data !== exp_basic[NB - 1]) begin
            miscompares++;
            $display("[TB] FAIL basic_tx_data_hold: got %0h want %0h", tx_data, exp_basic[NB - 1]);
        end
    endtask

    task automatic test_pattern();
        int k, bf;
        bit ok;
        logic [7:0] e;
        en1          = 1'b0;
        en2          = 1'b1;
        pulse_width1 = 16'h1234;
        pulse_width2 = 16'hFF01;
        pulse_gap    = 16'hA5A5;
        bf = flag_data.size();
        pulse_req(k);
        wait_done(NB * SLOT + 20, ok);
        idle(2);
        vectors++;
        if (!ok || flag_data.size() - bf != NB) begin
            miscompares++;
            $display("[TB] FAIL pattern_frame: done %0b flags %0d want 1 %0d", ok, flag_data.size() - bf, NB);
        end
        for (int i = 0; i < NB; i++) begin
            e = model_byte(i, 1'b0, 1'b1, 16'h1234, 16'hFF01, 16'hA5A5);
            if (bf + i < flag_data.size()) begin
                vectors++;
                if (flag_data[bf + i] !== e) begin
                    miscompares++;
                    $display("[TB] FAIL pattern_byte%0d: got %0h want %0h", i, flag_data[bf + i], e);
                end
            end
        end
    endtask

    task automatic test_ignore_done();
        int k, bf;
        bit ok;
        set_basic();
        bf = flag_data.size();
        pulse_req(k);
        wait_done(NB * SLOT + 20, ok);
        send_req = 1'b1;
        @(negedge sys_clk);
        send_req = 1'b0;
        idle(2 * SLOT);
        vectors++;
        if (!ok || flag_data.size() - bf != NB || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_during_done: flags %0d busy %0b want %0d 0", flag_data.size() - bf, busy, NB);
        end
    endtask

    task automatic test_snapshot();
        int k, kd, bf, bd;
        bit ok, okf;
        set_basic();
        bf = flag_data.size();
        bd = done_cnt;
        pulse_req(k);
        wait_flags(bf + 3, 4 * SLOT, okf);
        pulse_width1 = 16'hABCD;
        pulse_req(kd);
        wait_done(NB * SLOT + 20, ok);
        idle(3 * SLOT);
        vectors++;
        if (!ok || !okf) begin miscompares++; $display("[TB] FAIL snapshot_timeout: flag %0b done %0b want 1 1", okf, ok); end
        vectors++;
        if (flag_data.size() - bf != NB) begin
            miscompares++;
            $display("[TB] FAIL snapshot_flag_count: got %0d want %0d", flag_data.size() - bf, NB);
        end
        vectors++;
        if (done_cnt - bd != 1) begin miscompares++; $display("[TB] FAIL snapshot_done_count: got %0d want 1", done_cnt - bd); end
        if (flag_data.size() - bf >= 5) begin
            vectors++;
            if (flag_data[bf + 3] !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL snapshot_byte3: got %0h want 00", flag_data[bf + 3]);
            end
            vectors++;
            if (flag_data[bf + 4] !== 8'h08) begin
                miscompares++;
                $display("[TB] FAIL snapshot_byte4: got %0h want 08", flag_data[bf + 4]);
            end
        end
        pulse_width1 = 16'h0008;
    endtask

    task automatic test_reset_mid();
        int k, bf, br;
        bit ok, okf;
        set_basic();
        bf = flag_data.size();
        pulse_req(k);
        wait_flags(bf + 5, 6 * SLOT, okf);
        idle(3);
        sys_rst_n = 1'b0;
        #1;
        vectors++;
        if (!okf) begin miscompares++; $display("[TB] FAIL rstmid_reach_byte4: not reached"); end
        vectors++;
        if (tx_data !== 8'h00 || tx_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_outputs: data %0h flag %0b busy %0b done %0b want 0 0 0 0",
                     tx_data, tx_flag, busy, done);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        br = flag_data.size();
        idle(3 * SLOT);
        vectors++;
        if (flag_data.size() != br || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_quiet: flags %0d busy %0b want 0 0", flag_data.size() - br, busy);
        end
        pulse_req(k);
        wait_done(NB * SLOT + 20, ok);
        idle(2);
        vectors++;
        if (!ok || flag_data.size() - br != NB) begin
            miscompares++;
            $display("[TB] FAIL rstmid_refill: done %0b flags %0d want 1 %0d", ok, flag_data.size() - br, NB);
        end
        for (int i = 0; i < NB; i++) begin
            if (br + i < flag_data.size()) begin
                vectors++;
                if (flag_data[br + i] !== exp_basic[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rstmid_byte%0d: got %0h want %0h", i, flag_data[br + i], exp_basic[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k1, k2, bf;
        bit ok1, ok2;
        set_basic();
        bf = flag_data.size();
        pulse_req(k1);
        wait_done(NB * SLOT + 20, ok1);
        @(negedge sys_clk);
        send_req = 1'b1;
        k2 = cyc + 1;
        @(negedge sys_clk);
        send_req = 1'b0;
        wait_done(NB * SLOT + 20, ok2);
        idle(2);
        vectors++;
        if (!ok1 || !ok2) begin miscompares++; $display("[TB] FAIL b2b_timeout: done %0b %0b want 1 1", ok1, ok2); end
        vectors++;
        if (k2 - k1 != NB * SLOT + 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_req_edge: got %0d want %0d", k2 - k1, NB * SLOT + 2);
        end
        vectors++;
        if (flag_data.size() - bf != 2 * NB) begin
            miscompares++;
            $display("[TB] FAIL b2b_flag_count: got %0d want %0d", flag_data.size() - bf, 2 * NB);
        end
        if (flag_data.size() - bf == 2 * NB) begin
            vectors++;
            if (flag_cyc[bf + NB] - k2 != 1) begin
                miscompares++;
                $display("[TB] FAIL b2b_latency: got %0d want 1", flag_cyc[bf + NB] - k2);
            end
            for (int i = 1; i < NB; i++) begin
                vectors++;
                if (flag_cyc[bf + NB + i] - flag_cyc[bf + NB + i - 1] != SLOT) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d want %0d", i,
                             flag_cyc[bf + NB + i] - flag_cyc[bf + NB + i - 1], SLOT);
                end
            end
            for (int i = 0; i < NB; i++) begin
                vectors++;
                if (flag_data[bf + NB + i] !== exp_basic[i]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_byte%0d: got %0h want %0h", i, flag_data[bf + NB + i], exp_basic[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        exp_basic    = '{8'h07, 8'h01, 8'h01, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h12, 8'h28};
        sys_rst_n    = 1'b1;
        send_req     = 1'b0;
        set_basic();
        test_reset();
        test_basic_frame();
        test_pattern();
        test_ignore_done();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
